// File: rtl/run_control.sv
// Run/stop controller for the MiniSRC datapath.
// Sequences the datapath clear, free run and instruction stepping, and stops
// on a stop request, a PC breakpoint, a cycle limit or the end of a step.
// It also counts run cycles and fetched instructions and records why it halted.
module run_control #(
    parameter int ADDR_W     = 32,
    parameter int NUM_BP     = 4,
    parameter int CNT_W      = 32,
    parameter int STEP_W     = 8,
    parameter int CLR_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              step_req,
    input  logic [STEP_W-1:0] step_count,
    input  logic              soft_clr,
    input  logic [CNT_W-1:0]  max_cycles,
    input  logic              instr_fetch,
    input  logic [ADDR_W-1:0] pc_data,
    input  logic              bp_wr_en,
    input  logic [3:0]        bp_wr_idx,
    input  logic [ADDR_W-1:0] bp_wr_addr,
    input  logic              bp_wr_valid,
    output logic              run,
    output logic              clr,
    output logic              halted,
    output logic [2:0]        halt_cause,
    output logic [3:0]        bp_hit_idx,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [CNT_W-1:0]  instr_count
);

    typedef enum logic [2:0] {
        S_CLR,
        S_IDLE,
        S_RUN,
        S_STEP,
        S_HALTED
    } state_e;

    localparam logic [2:0] CAUSE_NONE  = 3'd0;
    localparam logic [2:0] CAUSE_STOP  = 3'd1;
    localparam logic [2:0] CAUSE_BP    = 3'd2;
    localparam logic [2:0] CAUSE_LIMIT = 3'd3;
    localparam logic [2:0] CAUSE_STEP  = 3'd4;

    localparam int              CLR_W    = $clog2(CLR_CYCLES + 1);
    localparam logic [CLR_W-1:0] CLR_LOAD = CLR_W'(CLR_CYCLES - 1);

    state_e              state_q, state_d;
    logic [CLR_W-1:0]    clr_cnt_q, clr_cnt_d;
    logic [STEP_W-1:0]   remaining_q, remaining_d;
    logic                skip_q, skip_d;
    logic [CNT_W-1:0]    cycle_q, cycle_d;
    logic [CNT_W-1:0]    instr_q, instr_d;
    logic [2:0]          cause_q, cause_d;
    logic [3:0]          bp_idx_q, bp_idx_d;
    logic                run_q, run_d;
    logic                clr_q, clr_d;
    logic                halted_q, halted_d;

    logic [ADDR_W-1:0]   bp_addr_q [NUM_BP];
    logic [NUM_BP-1:0]   bp_valid_q;

    logic                bp_match;
    logic [3:0]          bp_match_idx;
    logic                limit_hit;
    logic                halt_now;

    // Breakpoint enable bits: reset to invalid, rewritten by the write port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bp_valid_q <= '0;
        end else if (bp_wr_en) begin
            // NOTE: sequential state uses non-blocking assignments so every flop
            // samples pre-edge values regardless of statement order.
            for (int i = 0; i < NUM_BP; i++) begin
                if (bp_wr_idx == 4'(i)) bp_valid_q[i] <= bp_wr_valid;
            end
        end
    end

    // Breakpoint addresses; indices beyond NUM_BP never match a slot.
    // NOTE: the address array has no reset because its valid bit gates every use.
    always_ff @(posedge clk) begin
        if (bp_wr_en) begin
            for (int i = 0; i < NUM_BP; i++) begin
                if (bp_wr_idx == 4'(i)) bp_addr_q[i] <= bp_wr_addr;
            end
        end
    end

    // Compare the PC against all valid breakpoints, keeping the lowest index.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        bp_match     = 1'b0;
        bp_match_idx = '0;
        for (int i = NUM_BP - 1; i >= 0; i--) begin
            if (bp_valid_q[i] && (bp_addr_q[i] == pc_data)) begin
                bp_match     = 1'b1;
                bp_match_idx = 4'(i);
            end
        end
    end

    assign limit_hit = (max_cycles != '0) && (cycle_q == (max_cycles - CNT_W'(1)));

    // Next-state, counter and halt-cause logic.
    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        remaining_d = remaining_q;
        skip_d      = skip_q;
        cycle_d     = cycle_q;
        instr_d     = instr_q;
        cause_d     = cause_q;
        bp_idx_d    = bp_idx_q;
        halt_now    = 1'b0;

        if (soft_clr) begin
            state_d   = S_CLR;
            clr_cnt_d = CLR_LOAD;
            cycle_d   = '0;
            instr_d   = '0;
            cause_d   = CAUSE_NONE;
            skip_d    = 1'b0;
        end else begin
            unique case (state_q)
                S_CLR: begin
                    cycle_d = '0;
                    instr_d = '0;
                    cause_d = CAUSE_NONE;
                    if (clr_cnt_q == '0) state_d = S_IDLE;
                    else                 clr_cnt_d = clr_cnt_q - CLR_W'(1);
                end
                S_IDLE, S_HALTED: begin
                    if (!stop && start) begin
                        state_d = S_RUN;
                        cause_d = CAUSE_NONE;
                        skip_d  = (state_q == S_HALTED);
                    end else if (!stop && step_req) begin
                        state_d     = S_STEP;
                        cause_d     = CAUSE_NONE;
                        skip_d      = (state_q == S_HALTED);
                        remaining_d = (step_count == '0) ? STEP_W'(1) : step_count;
                    end
                end
                S_RUN, S_STEP: begin
                    if (!(&cycle_q))                instr_d = instr_q;
                    if (!(&cycle_q))                cycle_d = cycle_q + CNT_W'(1);
                    if (instr_fetch && !(&instr_q)) instr_d = instr_q + CNT_W'(1);
                    if (instr_fetch)                skip_d  = 1'b0;

                    if (stop) begin
                        halt_now = 1'b1;
                        cause_d  = CAUSE_STOP;
                    end else if (instr_fetch && bp_match && !skip_q) begin
                        halt_now = 1'b1;
                        cause_d  = CAUSE_BP;
                        bp_idx_d = bp_match_idx;
                    end else if (limit_hit) begin
                        halt_now = 1'b1;
                        cause_d  = CAUSE_LIMIT;
                    end else if ((state_q == S_STEP) && instr_fetch) begin
                        if (remaining_q == STEP_W'(1)) begin
                            halt_now = 1'b1;
                            cause_d  = CAUSE_STEP;
                        end else begin
                            remaining_d = remaining_q - STEP_W'(1);
                        end
                    end

                    if (halt_now) state_d = S_HALTED;
                end
                default: begin
                    state_d   = S_CLR;
                    clr_cnt_d = CLR_LOAD;
                end
            endcase
        end

        run_d    = (state_d == S_RUN) || (state_d == S_STEP);
        clr_d    = (state_d == S_CLR);
        halted_d = (state_d == S_HALTED);
    end

    // State, counters and registered outputs; reset enters the clear sequence.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_CLR;
            clr_cnt_q   <= CLR_LOAD;
            remaining_q <= '0;
            skip_q      <= 1'b0;
            cycle_q     <= '0;
            instr_q     <= '0;
            cause_q     <= CAUSE_NONE;
            bp_idx_q    <= '0;
            run_q       <= 1'b0;
            clr_q       <= 1'b1;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            remaining_q <= remaining_d;
            skip_q      <= skip_d;
            cycle_q     <= cycle_d;
            instr_q     <= instr_d;
            cause_q     <= cause_d;
            bp_idx_q    <= bp_idx_d;
            run_q       <= run_d;
            clr_q       <= clr_d;
            halted_q    <= halted_d;
        end
    end

    assign run         = run_q;
    assign clr         = clr_q;
    assign halted      = halted_q;
    assign halt_cause  = cause_q;
    assign bp_hit_idx  = bp_idx_q;
    assign cycle_count = cycle_q;
    assign instr_count = instr_q;

endmodule
